// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin select sequencer for a downstream 8:1 mux.
// Picks the next requesting channel, waits a programmable settle dwell,
// then presents the settled mux output until the consumer acknowledges.
module mux_sel_scanner #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ack,
  output logic               S0,
  output logic               S1,
  output logic               S2,
  output logic               valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         sel;
  logic [2:0]         ptr;
  logic [DWELL_W-1:0] cnt;

  logic [2:0]         next_ch;
  logic               next_hit;
  logic [2:0]         scan_idx;

  // Round-robin search: first set req bit starting at ptr+1, wrapping 7->0,
  // with ptr itself checked last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    next_ch  = ptr;
    next_hit = 1'b0;
    scan_idx = ptr;
    for (int k = 1; k <= 8; k++) begin
      scan_idx = ptr + 3'(k);
      if (!next_hit && req[scan_idx]) begin
        next_ch  = scan_idx;
        next_hit = 1'b1;
      end
    end
  end

  // Sequencer: IDLE picks a channel, SETTLE counts the dwell down,
  // PRESENT holds valid until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd7;
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, independent of statement order.
      unique case (state)
        IDLE: begin
          if (enable && next_hit) begin
            sel   <= next_ch;
            cnt   <= dwell;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            valid <= 1'b1;
            state <= PRESENT;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            ptr   <= sel;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // Select bits and busy decode straight from registers; no input-to-output path.
  assign S0   = sel[0];
  assign S1   = sel[1];
  assign S2   = sel[2];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb_mux_sel_scanner: directed scenario bench for mux_sel_scanner.
// Each sample compares obs = {S2,S1,S0,valid,busy} to a hand-derived value.
module tb_mux_sel_scanner;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [3:0] dwell;
  logic       ack;
  logic       S0, S1, S2, valid, busy;

  int pass_cnt;
  int total_cnt;

  logic [4:0] obs;
  assign obs = {S2, S1, S0, valid, busy};

  mux_sel_scanner #(.DWELL_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .req    (req),
    .dwell  (dwell),
    .ack    (ack),
    .S0     (S0),
    .S1     (S1),
    .S2     (S2),
    .valid  (valid),
    .busy   (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: assert between edges, check immediately, release between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (obs !== 5'b000_0_0)
      $display("FAIL reset_async got sel=%0d valid=%0b busy=%0b want sel=0 valid=0 busy=0",
               obs[4:2], obs[1], obs[0]);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; req = 8'h00; dwell = 4'd0; ack = 1'b0;
    #2;
    do_reset();
    total_cnt++;
    if (obs !== 5'b000_0_0)
      $display("FAIL reset_release got sel=%0d valid=%0b busy=%0b want sel=0 valid=0 busy=0",
               obs[4:2], obs[1], obs[0]);
    else pass_cnt++;
  endtask

  // Single request ch0, dwell=0, ack held: valid one edge, busy two edges.
  task automatic test_single();
    logic [4:0] exp_obs [4];
    exp_obs[0] = 5'b000_0_1;  // SETTLE
    exp_obs[1] = 5'b000_1_1;  // PRESENT
    exp_obs[2] = 5'b000_0_0;  // IDLE after ack
    exp_obs[3] = 5'b000_0_0;  // stays IDLE, req cleared
    enable = 1'b1; req = 8'h01; dwell = 4'd0; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      req = 8'h00;
      total_cnt++;
      if (obs !== exp_obs[i])
        $display("FAIL single_edge%0d got obs=%05b want obs=%05b", i + 1, obs, exp_obs[i]);
      else pass_cnt++;
    end
  endtask

  // All requests, dwell=2, ack tied high: channels 0..7,0 one every 5 edges.
  task automatic test_scan_wrap();
    logic [2:0] ch;
    int         ph;
    logic [4:0] want;
    enable = 1'b0; req = 8'h00;
    do_reset();
    enable = 1'b1; req = 8'hFF; dwell = 4'd2; ack = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      tick();
      ph   = (n - 1) % 5;
      ch   = 3'(((n - 1) / 5) % 8);
      want = {ch, (ph == 3), (ph != 4)};
      total_cnt++;
      if (obs !== want)
        $display("FAIL scan_edge%0d got obs=%05b want obs=%05b", n, obs, want);
      else pass_cnt++;
    end
    req = 8'h00;
    tick();
  endtask

  // Serve ch5, then req={ch5,ch2}: search from ch6 wraps to ch2.
  task automatic test_ptr_wrap();
    enable = 1'b1; req = 8'h20; dwell = 4'd0; ack = 1'b1;
    tick();
    req = 8'h00;
    total_cnt++;
    if (obs !== 5'b101_0_1)
      $display("FAIL ptr_serve5 got obs=%05b want obs=10101", obs);
    else pass_cnt++;
    tick();
    tick();
    req = 8'b0010_0100;
    tick();
    req = 8'h00;
    total_cnt++;
    if (obs !== 5'b010_0_1)
      $display("FAIL ptr_wrap_to2 got obs=%05b want obs=01001", obs);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (obs !== 5'b010_0_0)
      $display("FAIL ptr_wrap_done got obs=%05b want obs=01000", obs);
    else pass_cnt++;
  endtask

  // dwell=15 on ch3, enable dropped in 4th SETTLE cycle: abort, ptr stays at 2.
  task automatic test_abort();
    logic [4:0] want;
    enable = 1'b1; req = 8'h08; dwell = 4'd15; ack = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 1) req = 8'h00;
      if (n == 4) enable = 1'b0;
      want = (n <= 4) ? 5'b011_0_1 : 5'b011_0_0;
      total_cnt++;
      if (obs !== want)
        $display("FAIL abort_edge%0d got obs=%05b want obs=%05b", n, obs, want);
      else pass_cnt++;
    end
    // ptr still 2 -> search starts at ch3 (ptr=3 would pick ch2).
    enable = 1'b1; req = 8'h0C; dwell = 4'd0;
    tick();
    req = 8'h00;
    total_cnt++;
    if (obs !== 5'b011_0_1)
      $display("FAIL abort_ptr_kept got obs=%05b want obs=01101", obs);
    else pass_cnt++;
    tick();
    tick();
  endtask

  // PRESENT with ack low 10 edges, req cleared, enable low: everything holds.
  task automatic test_hold();
    enable = 1'b1; req = 8'h02; dwell = 4'd1; ack = 1'b0;
    tick();
    req = 8'h00;
    tick();
    tick();
    enable = 1'b0;
    total_cnt++;
    if (obs !== 5'b001_1_1)
      $display("FAIL hold_present got obs=%05b want obs=00111", obs);
    else pass_cnt++;
    for (int n = 1; n <= 10; n++) begin
      tick();
      total_cnt++;
      if (obs !== 5'b001_1_1)
        $display("FAIL hold_edge%0d got obs=%05b want obs=00111", n, obs);
      else pass_cnt++;
    end
    ack = 1'b1;
    tick();
    total_cnt++;
    if (obs !== 5'b001_0_0)
      $display("FAIL hold_ack_drop got obs=%05b want obs=00100", obs);
    else pass_cnt++;
  endtask

  // Async reset mid-PRESENT clears outputs at once; next search starts at ch0.
  task automatic test_async_reset();
    enable = 1'b1; req = 8'h10; dwell = 4'd0; ack = 1'b0;
    tick();
    req = 8'h00;
    tick();
    total_cnt++;
    if (obs !== 5'b100_1_1)
      $display("FAIL areset_present got obs=%05b want obs=10011", obs);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 5'b000_0_0)
      $display("FAIL areset_immediate got obs=%05b want obs=00000", obs);
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    req = 8'h11; ack = 1'b1;
    tick();
    req = 8'h00;
    total_cnt++;
    if (obs !== 5'b000_0_1)
      $display("FAIL areset_search_ch0 got obs=%05b want obs=00001", obs);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== 5'b000_1_1)
      $display("FAIL areset_new_valid got obs=%05b want obs=00011", obs);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== 5'b000_0_0)
      $display("FAIL areset_done got obs=%05b want obs=00000", obs);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b1;
    test_reset();
    test_single();
    test_scan_wrap();
    test_ptr_wrap();
    test_abort();
    test_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_sel_scanner.md
MUX_SEL_SCANNER -- requirements
Module: mux_sel_scanner

Interface
REQ-001 SHALL have parameter DWELL_W, default 4, width of the settle-dwell count.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1, scan enable.
REQ-005 SHALL have port req, input, 8, per-channel service request; bit i maps to data input Di of the downstream 8:1 mux.
REQ-006 SHALL have port dwell, input, DWELL_W, extra settle cycles after a select change.
REQ-007 SHALL have port ack, input, 1, consumer accepts the presented channel.
REQ-008 SHALL have ports S0, S1, S2, output, 1 each, mux select bits; S2 is the MSB and {S2,S1,S0} is the channel index.
REQ-009 SHALL have port valid, output, 1, mux output is settled and ready to consume.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, SETTLE and PRESENT, encoded in a registered state variable.
REQ-012 In IDLE with enable=1 and req!=0, the block SHALL perform these actions on the next edge:
- select the first set req bit, searching round-robin from (ptr+1) mod 8 upward, with wrap 7->0;
- drive that index onto {S2,S1,S0};
- load cnt=dwell;
- enter SETTLE.
REQ-013 In IDLE with enable=0 or req==0, all outputs SHALL hold and the state SHALL remain IDLE.
REQ-014 In SETTLE, the block SHALL behave as follows:
- if cnt==0, set valid=1 and enter PRESENT on the next edge;
- otherwise decrement cnt by 1.
REQ-015 Select-to-valid latency SHALL therefore be dwell+1 edges, which is 1 edge for dwell=0 and 16 edges for dwell=15.
REQ-016 In SETTLE with enable=0, the block SHALL abort on the next edge:
- go to IDLE;
- keep valid=0;
- leave ptr unchanged;
- hold S bits at their last value.
REQ-017 The req bits SHALL be sampled only at selection; a change of req during SETTLE or PRESENT SHALL have no effect on the current transaction.
REQ-018 In PRESENT, valid SHALL stay 1 and the S bits SHALL stay stable until ack=1 is sampled, regardless of enable.
REQ-019 On an edge with ack=1 in PRESENT, the block SHALL:
- set valid=0;
- set ptr to the presented channel;
- enter IDLE, giving one IDLE cycle between transactions.
REQ-020 ack SHALL be ignored outside PRESENT.
REQ-021 The S bits SHALL change only on an IDLE->SETTLE transition and SHALL never change while valid=1.
REQ-022 cnt SHALL be DWELL_W bits wide and SHALL never underflow, because the decrement occurs only when cnt!=0.
REQ-023 busy SHALL equal 1 in SETTLE and PRESENT, as a registered or decoded-from-state output with no combinational path from inputs.
REQ-024 With the same single req bit held continuously, that channel SHALL be re-served every dwell+3 edges.

Reset
REQ-025 While rst_n=0, the block SHALL, immediately and without waiting for clk:
- set state=IDLE;
- set S2=S1=S0=0;
- set valid=0 and busy=0;
- set cnt=0;
- set ptr=7, so that the first search starts at channel 0.
REQ-026 Deassertion of rst_n mid-transaction SHALL discard the transaction; no valid pulse from the pre-reset transaction SHALL appear after reset is released.
REQ-027 The first edge after rst_n rises SHALL be treated as an ordinary IDLE cycle.

Verification
REQ-028 Scenario: reset, then enable=1, req=8'h01, dwell=0, ack=1 held -> S=000, valid high for one edge two edges after req, busy high for 2 edges.
REQ-029 Scenario: req=8'hFF held, dwell=2, ack tied 1 -> S sequence 0,1,2,...,7,0 (wraps), valid pulse every 5 edges.
REQ-030 Scenario: ptr=5 after serving ch5, req=8'b0010_0100 -> next select is ch2 via wrap, not ch5.
REQ-031 Scenario: dwell=15, enable dropped at the 4th SETTLE cycle -> IDLE next edge, valid never asserts, ptr unchanged.
REQ-032 Scenario: PRESENT with ack=0 for 10 edges, with req cleared and enable=0 -> valid and S held all 10 edges; valid drops one edge after ack=1.
REQ-033 Scenario: rst_n pulsed low asynchronously between edges during PRESENT -> valid, S and busy go to 0 immediately; the next transaction starts its search at ch0.
